// File: rtl/mem_access_unit_pkg.sv
// Shared definitions for the MEM-stage access unit: size codes, FSM states
// and the request legality check applied at accept time.
package mem_access_unit_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    typedef enum logic [1:0] {
        S_IDLE   = 2'b00,
        S_LOAD   = 2'b01,
        S_RMW_RD = 2'b10,
        S_WRITE  = 2'b11
    } state_t;

    // Flags misaligned halves/words, the reserved size code and word indices past the memory.
    function automatic logic accessError(input logic [1:0] size, input logic [31:0] addr,
                                         input int unsigned depth);
        logic        bad;
        logic [31:0] wordIdx;
        bad     = 1'b0;
        wordIdx = {2'b00, addr[31:2]};
        case (size)
            SZ_BYTE: bad = 1'b0;
            SZ_HALF: bad = addr[0];
            SZ_WORD: bad = |addr[1:0];
            default: bad = 1'b1;
        endcase
        if (wordIdx >= depth) begin
            bad = 1'b1;
        end
        return bad;
    endfunction

endpackage

// File: rtl/mem_access_unit_lsu_lane_align.sv
// Combinational byte-lane steering: load extract with sign/zero extension,
// and store merge of a sub-word into an existing memory word.
module lsu_lane_align
    import mem_access_unit_pkg::*;
(
    input  logic [31:0] i_rdWord,
    input  logic [31:0] i_oldWord,
    input  logic [31:0] i_wdata,
    input  logic [1:0]  i_offset,
    input  logic [1:0]  i_size,
    input  logic        i_unsigned,
    output logic [31:0] o_loadData,
    output logic [31:0] o_mergeWord
);

    logic [4:0]  w_shift;
    logic [31:0] w_lane;
    logic [31:0] w_mask;

    // Word accesses are always aligned, so only sub-word sizes shift the lane.
    always_comb begin
        w_shift = 5'd0;
        w_mask  = 32'hFFFF_FFFF;
        case (i_size)
            SZ_BYTE: begin
                w_shift = {i_offset, 3'b000};
                w_mask  = 32'h0000_00FF << w_shift;
            end
            SZ_HALF: begin
                w_shift = {i_offset[1], 4'b0000};
                w_mask  = 32'h0000_FFFF << w_shift;
            end
            default: begin
                w_shift = 5'd0;
                w_mask  = 32'hFFFF_FFFF;
            end
        endcase

        w_lane = i_rdWord >> w_shift;
        case (i_size)
            SZ_BYTE: o_loadData = i_unsigned ? {24'd0, w_lane[7:0]}
                                             : {{24{w_lane[7]}}, w_lane[7:0]};
            SZ_HALF: o_loadData = i_unsigned ? {16'd0, w_lane[15:0]}
                                             : {{16{w_lane[15]}}, w_lane[15:0]};
            default: o_loadData = w_lane;
        endcase

        o_mergeWord = (i_oldWord & ~w_mask) | ((i_wdata << w_shift) & w_mask);
    end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage initiator for a word-wide memory without byte enables; sub-word
// stores become a read-modify-write, loads are lane-extracted and extended.
module mem_access_unit
    import mem_access_unit_pkg::*;
#(
    parameter int DW    = 32,
    parameter int DEPTH = 1024
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic          req_we,
    input  logic [1:0]    req_size,
    input  logic          req_unsigned,
    input  logic [31:0]   req_addr,
    input  logic [DW-1:0] req_wdata,
    output logic          rsp_valid,
    output logic [DW-1:0] rsp_rdata,
    output logic          rsp_err,
    output logic          mem_rw,
    output logic [31:0]   mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata
);

    state_t        r_state;
    logic [1:0]    r_size;
    logic          r_unsigned;
    logic [31:0]   r_addr;
    logic [DW-1:0] r_wdata;
    logic [DW-1:0] r_mergeWord;
    logic          r_rspValid;
    logic [DW-1:0] r_rspRdata;
    logic          r_rspErr;

    logic          w_reqErr;
    logic [DW-1:0] w_loadData;
    logic [DW-1:0] w_mergeWord;

    assign w_reqErr  = accessError(req_size, req_addr, DEPTH);
    assign req_ready = (r_state == S_IDLE);
    assign rsp_valid = r_rspValid;
    assign rsp_rdata = r_rspRdata;
    assign rsp_err   = r_rspErr;
    assign mem_addr  = {2'b00, r_addr[31:2]};
    assign mem_wdata = w_mergeWord;
    // Gating with reset keeps a write from landing in the cycle reset aborts an access.
    assign mem_rw    = (r_state == S_WRITE) && !reset;

    lsu_lane_align u_align (
        .i_rdWord    (mem_rdata),
        .i_oldWord   (r_mergeWord),
        .i_wdata     (r_wdata),
        .i_offset    (r_addr[1:0]),
        .i_size      (r_size),
        .i_unsigned  (r_unsigned),
        .o_loadData  (w_loadData),
        .o_mergeWord (w_mergeWord)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_size      <= SZ_BYTE;
            r_unsigned  <= 1'b0;
            r_addr      <= 32'd0;
            r_wdata     <= '0;
            r_mergeWord <= '0;
            r_rspValid  <= 1'b0;
            r_rspRdata  <= '0;
            r_rspErr    <= 1'b0;
        end else begin
            r_rspValid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (req_valid) begin
                        r_size     <= req_size;
                        r_unsigned <= req_unsigned;
                        r_addr     <= req_addr;
                        r_wdata    <= req_wdata;
                        if (w_reqErr) begin
                            r_rspValid <= 1'b1;
                            r_rspErr   <= 1'b1;
                            r_rspRdata <= '0;
                        end else if (!req_we) begin
                            r_state <= S_LOAD;
                        end else if (req_size == SZ_WORD) begin
                            r_state <= S_WRITE;
                        end else begin
                            r_state <= S_RMW_RD;
                        end
                    end
                end
                S_LOAD: begin
                    r_rspValid <= 1'b1;
                    r_rspErr   <= 1'b0;
                    r_rspRdata <= w_loadData;
                    r_state    <= S_IDLE;
                end
                S_RMW_RD: begin
                    r_mergeWord <= mem_rdata;
                    r_state     <= S_WRITE;
                end
                S_WRITE: begin
                    r_rspValid <= 1'b1;
                    r_rspErr   <= 1'b0;
                    r_rspRdata <= '0;
                    r_state    <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: vector table for single accesses plus
// hand sequences for reset-abort and back-to-back issue.
module tb_mem_access_unit;

    logic        clk;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        mem_rw;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    logic [31:0] memModel [1024];
    int          checks;
    int          errors;

    typedef struct {
        logic        we;
        logic [1:0]  size;
        logic        uns;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] expRdata;
        logic        expErr;
        int          expLat;
        int          expWrites;
    } vec_t;

    vec_t vecs [15];

    mem_access_unit #(.DW(32), .DEPTH(1024)) dut (
        .clk          (clk),
        .reset        (reset),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_we       (req_we),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .rsp_valid    (rsp_valid),
        .rsp_rdata    (rsp_rdata),
        .rsp_err      (rsp_err),
        .mem_rw       (mem_rw),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_rdata    (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Word-wide memory with combinational read and clocked write.
    assign mem_rdata = memModel[mem_addr[9:0]];
    always @(posedge clk) begin
        if (mem_rw) memModel[mem_addr[9:0]] <= mem_wdata;
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic we, input logic [1:0] size, input logic uns,
                                input logic [31:0] addr, input logic [31:0] wdata,
                                input logic [31:0] expRdata, input logic expErr,
                                input int expLat, input int expWrites);
        vec_t v;
        v.we = we; v.size = size; v.uns = uns; v.addr = addr; v.wdata = wdata;
        v.expRdata = expRdata; v.expErr = expErr; v.expLat = expLat; v.expWrites = expWrites;
        return v;
    endfunction

    task automatic driveReq(input vec_t v);
        req_valid    = 1'b1;
        req_we       = v.we;
        req_size     = v.size;
        req_unsigned = v.uns;
        req_addr     = v.addr;
        req_wdata    = v.wdata;
    endtask

    // One isolated access: drive on a negedge, accept on the next posedge, then time the response.
    task automatic applyStimulus(input int idx, input vec_t v);
        int lat;
        int writes;
        bit seen;
        string tag;
        tag = $sformatf("v%0d", idx);
        @(negedge clk);
        checkOutput({tag, "_ready"}, {31'd0, req_ready}, 32'd1);
        driveReq(v);
        @(posedge clk);
        lat = 0;
        writes = 0;
        seen = 1'b0;
        for (int k = 1; k <= 8 && !seen; k++) begin
            @(negedge clk);
            if (k == 1) req_valid = 1'b0;
            if (mem_rw) writes++;
            if (rsp_valid) begin
                seen = 1'b1;
                lat = k;
            end
        end
        checkOutput({tag, "_latency"}, lat, v.expLat);
        checkOutput({tag, "_err"}, {31'd0, rsp_err}, {31'd0, v.expErr});
        checkOutput({tag, "_rdata"}, rsp_rdata, v.expRdata);
        checkOutput({tag, "_writes"}, writes, v.expWrites);
    endtask

    // Sub-word store aborted by reset after 1 (RMW_RD) or 2 (WRITE) cycles.
    task automatic resetMidAccess(input int cyclesIn);
        int rspSeen;
        int writes;
        @(negedge clk);
        driveReq(mk(1'b1, 2'b00, 1'b0, 32'h10, 32'h77, 32'h0, 1'b0, 0, 0));
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        if (cyclesIn == 2) @(negedge clk);
        reset = 1'b1;
        #1;
        checkOutput($sformatf("rst%0d_memrw_in_reset", cyclesIn), {31'd0, mem_rw}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        rspSeen = 0;
        writes = 0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            if (rsp_valid) rspSeen++;
            if (mem_rw) writes++;
        end
        checkOutput($sformatf("rst%0d_no_rsp", cyclesIn), rspSeen, 32'd0);
        checkOutput($sformatf("rst%0d_no_write", cyclesIn), writes, 32'd0);
        checkOutput($sformatf("rst%0d_ready", cyclesIn), {31'd0, req_ready}, 32'd1);
        checkOutput($sformatf("rst%0d_word4", cyclesIn), memModel[4], 32'hA5AD8001);
    endtask

    // Three requests with req_valid held; each must be accepted in the previous response's cycle.
    task automatic backToBack();
        vec_t ops [3];
        int issueIdx;
        int rspIdx;
        bit pending;
        ops[0] = mk(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 32'hA5AD8001, 1'b0, 0, 0);
        ops[1] = mk(1'b1, 2'b10, 1'b0, 32'h20, 32'h12345678, 32'h0, 1'b0, 0, 0);
        ops[2] = mk(1'b0, 2'b00, 1'b0, 32'h20, 32'h0, 32'h00000078, 1'b0, 0, 0);
        issueIdx = 0;
        rspIdx = 0;
        pending = 1'b0;
        @(negedge clk);
        driveReq(ops[0]);
        for (int cyc = 0; cyc < 40 && rspIdx < 3; cyc++) begin
            if (cyc > 0) @(negedge clk);
            if (rsp_valid && rspIdx < 3) begin
                checkOutput($sformatf("b2b_rdata%0d", rspIdx), rsp_rdata, ops[rspIdx].expRdata);
                checkOutput($sformatf("b2b_err%0d", rspIdx), {31'd0, rsp_err}, 32'd0);
                rspIdx++;
            end
            if (pending) begin
                pending = 1'b0;
                issueIdx++;
                if (issueIdx < 3) driveReq(ops[issueIdx]);
                else req_valid = 1'b0;
            end
            if (req_valid && req_ready) begin
                if (issueIdx > 0)
                    checkOutput($sformatf("b2b_accept_with_rsp%0d", issueIdx),
                                {31'd0, rsp_valid}, 32'd1);
                pending = 1'b1;
            end
        end
        req_valid = 1'b0;
        checkOutput("b2b_rsp_count", rspIdx, 32'd3);
        checkOutput("b2b_word8", memModel[8], 32'h12345678);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        for (int i = 0; i < 1024; i++) memModel[i] = 32'd0;
        reset = 1'b1;
        req_valid = 1'b0;
        req_we = 1'b0;
        req_size = 2'b00;
        req_unsigned = 1'b0;
        req_addr = 32'd0;
        req_wdata = 32'd0;

        vecs[0]  = mk(1'b1, 2'b10, 1'b0, 32'h10,   32'hDEADBEEF, 32'h00000000, 1'b0, 2, 1);
        vecs[1]  = mk(1'b0, 2'b10, 1'b0, 32'h10,   32'h0,        32'hDEADBEEF, 1'b0, 2, 0);
        vecs[2]  = mk(1'b1, 2'b00, 1'b0, 32'h13,   32'h000000A5, 32'h00000000, 1'b0, 3, 1);
        vecs[3]  = mk(1'b0, 2'b00, 1'b0, 32'h13,   32'h0,        32'hFFFFFFA5, 1'b0, 2, 0);
        vecs[4]  = mk(1'b0, 2'b00, 1'b1, 32'h13,   32'h0,        32'h000000A5, 1'b0, 2, 0);
        vecs[5]  = mk(1'b1, 2'b01, 1'b0, 32'h10,   32'h00008001, 32'h00000000, 1'b0, 3, 1);
        vecs[6]  = mk(1'b0, 2'b01, 1'b0, 32'h10,   32'h0,        32'hFFFF8001, 1'b0, 2, 0);
        vecs[7]  = mk(1'b0, 2'b01, 1'b1, 32'h12,   32'h0,        32'h0000A5AD, 1'b0, 2, 0);
        vecs[8]  = mk(1'b0, 2'b10, 1'b0, 32'h10,   32'h0,        32'hA5AD8001, 1'b0, 2, 0);
        vecs[9]  = mk(1'b0, 2'b00, 1'b0, 32'h11,   32'h0,        32'hFFFFFF80, 1'b0, 2, 0);
        vecs[10] = mk(1'b0, 2'b00, 1'b1, 32'h12,   32'h0,        32'h000000AD, 1'b0, 2, 0);
        vecs[11] = mk(1'b0, 2'b10, 1'b0, 32'h11,   32'h0,        32'h00000000, 1'b1, 1, 0);
        vecs[12] = mk(1'b1, 2'b01, 1'b0, 32'h13,   32'h0000FFFF, 32'h00000000, 1'b1, 1, 0);
        vecs[13] = mk(1'b0, 2'b10, 1'b0, 32'h1000, 32'h0,        32'h00000000, 1'b1, 1, 0);
        vecs[14] = mk(1'b1, 2'b11, 1'b0, 32'h10,   32'h11111111, 32'h00000000, 1'b1, 1, 0);

        repeat (3) @(negedge clk);
        checkOutput("reset_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        checkOutput("reset_rsp_rdata", rsp_rdata, 32'd0);
        checkOutput("reset_rsp_err", {31'd0, rsp_err}, 32'd0);
        checkOutput("reset_mem_rw", {31'd0, mem_rw}, 32'd0);
        checkOutput("reset_mem_addr", mem_addr, 32'd0);
        checkOutput("reset_mem_wdata", mem_wdata, 32'd0);
        checkOutput("reset_ready", {31'd0, req_ready}, 32'd1);
        reset = 1'b0;

        for (int i = 0; i < 15; i++) begin
            applyStimulus(i, vecs[i]);
            if (i == 2) checkOutput("word4_after_sb", memModel[4], 32'hA5ADBEEF);
            if (i == 5) checkOutput("word4_after_sh", memModel[4], 32'hA5AD8001);
        end

        resetMidAccess(1);
        resetMidAccess(2);
        backToBack();

        repeat (2) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
